// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and defaults for the clock frequency monitor
package clk_mon_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } mon_state_t;

   // Defaults sized for a 200 MHz fabric clock: 10 ms window, ~20 us dead timeout
   localparam int DEF_CNT_W       = 24;
   localparam int DEF_GATE_CYCLES = 2000000;
   localparam int DEF_TIMEOUT     = 4096;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_mon_chan.sv
// rtl/clk_mon_chan.sv - per-channel synchroniser, edge counter, timeout and range check
module clk_mon_chan
   import clk_mon_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ch_tgl,
   input  logic             cnt_clr,
   input  logic             win_close,
   input  logic             win_latch,
   input  logic [CNT_W-1:0] exp_min,
   input  logic [CNT_W-1:0] exp_max,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             ch_ok,
   output logic             ch_alive
);

   localparam int               TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev;
   logic                   edge_det;
   logic [CNT_W-1:0]       edge_cnt;
   logic [CNT_W-1:0]       next_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic                   seen_q;

   // Shift the async toggle through the synchroniser, keep one extra sample for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], ch_tgl};
         sync_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   // Either polarity of the synchronised toggle is one source-clock edge; count saturates
   always_comb begin
      edge_det = sync_q[SYNC_STAGES-1] ^ sync_prev;
      next_cnt = edge_cnt;
      if (edge_det && (edge_cnt != CNT_MAX)) begin
         next_cnt = edge_cnt + CNT_W'(1);
      end
   end

   // Edge counter: cleared outside measurement and at every window boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
      end else if (cnt_clr || win_close) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= next_cnt;
      end
   end

   // Latch the closing window count (including a terminal-cycle edge) and its range verdict
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_cnt <= '0;
         ch_ok    <= 1'b0;
      end else if (win_latch) begin
         meas_cnt <= next_cnt;
         ch_ok    <= (next_cnt >= exp_min) && (next_cnt <= exp_max);
      end
   end

   // Dead-clock timer: restarts on every edge, sticks at the limit; runs regardless of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         seen_q <= 1'b0;
      end else if (edge_det) begin
         to_cnt <= '0;
         seen_q <= 1'b1;
      end else if (to_cnt != TO_LIMIT) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // A channel only becomes alive after its first edge following reset
   assign ch_alive = seen_q && (to_cnt < TO_LIMIT);

endmodule

// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - gated-window frequency monitor for NUM_CH async clock toggles
module clk_freq_monitor
   import clk_mon_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [NUM_CH-1:0]       ch_tgl,
   input  logic [NUM_CH*CNT_W-1:0] exp_min,
   input  logic [NUM_CH*CNT_W-1:0] exp_max,
   output logic [NUM_CH*CNT_W-1:0] meas_cnt,
   output logic                    meas_valid,
   output logic [NUM_CH-1:0]       ch_ok,
   output logic [NUM_CH-1:0]       ch_alive,
   output logic [NUM_CH-1:0]       hb_led
);

   localparam int                GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   mon_state_t        state;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_term;
   logic              measuring;
   logic              win_close;
   logic              win_latch;
   logic              hb_phase;

   // Window boundary decode; edge counters are held clear whenever not measuring
   always_comb begin
      gate_term = (gate_cnt == GATE_LAST);
      measuring = en && (state != ST_IDLE);
      win_close = measuring && gate_term;
      win_latch = win_close && (state == ST_RUN);
   end

   // Sequencer: one discarded warm-up window, then back-to-back measured windows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         gate_cnt   <= '0;
         meas_valid <= 1'b0;
      end else if (!en) begin
         state      <= ST_IDLE;
         gate_cnt   <= '0;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= win_latch;
         case (state)
            ST_IDLE: begin
               state    <= ST_WARMUP;
               gate_cnt <= '0;
            end
            ST_WARMUP: begin
               if (gate_term) begin
                  state    <= ST_RUN;
                  gate_cnt <= '0;
               end else begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
               end
            end
            ST_RUN: begin
               if (gate_term) begin
                  gate_cnt <= '0;
               end else begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               gate_cnt <= '0;
            end
         endcase
      end
   end

   // Heartbeat phase flips once per completed window, in step with meas_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_phase <= 1'b0;
      end else if (win_latch) begin
         hb_phase <= ~hb_phase;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_mon_chan #(
         .CNT_W       (CNT_W),
         .TIMEOUT     (TIMEOUT),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .ch_tgl    (ch_tgl[i]),
         .cnt_clr   (!measuring),
         .win_close (win_close),
         .win_latch (win_latch),
         .exp_min   (exp_min[i*CNT_W +: CNT_W]),
         .exp_max   (exp_max[i*CNT_W +: CNT_W]),
         .meas_cnt  (meas_cnt[i*CNT_W +: CNT_W]),
         .ch_ok     (ch_ok[i]),
         .ch_alive  (ch_alive[i])
      );
   end

   // LED: dark when dead, blinking when in range, solid when alive but out of range
   always_comb begin
      hb_led = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hb_led[i] = ch_alive[i] && (ch_ok[i] ? hb_phase : 1'b1);
      end
   end

endmodule
